// File: rtl/register_file_arbiter.sv
// register_file_arbiter: round-robin arbiter sharing one register_file port among NUM_REQUESTERS masters,
// one outstanding transaction at a time, with timeout and out-of-range error responses.
module register_file_arbiter #(
    parameter int DATA_WIDTH          = 8,
    parameter int REGISTER_FILE_DEPTH = 16,
    parameter int NUM_REQUESTERS      = 2,
    parameter int READ_TIMEOUT        = 4,
    localparam int ADDR_W = $clog2(REGISTER_FILE_DEPTH),
    localparam int GW     = $clog2(NUM_REQUESTERS),
    localparam int TW     = $clog2(READ_TIMEOUT + 1)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_REQUESTERS-1:0]            req_valid,
    input  logic [NUM_REQUESTERS-1:0]            req_write,
    input  logic [NUM_REQUESTERS*ADDR_W-1:0]     req_address,
    input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0] req_write_data,
    output logic [NUM_REQUESTERS-1:0]            req_ready,
    output logic [NUM_REQUESTERS-1:0]            rsp_valid,
    output logic                                 rsp_error,
    output logic [DATA_WIDTH-1:0]                rsp_data,
    output logic [ADDR_W-1:0]                    register_file_address,
    output logic                                 register_file_write_en,
    output logic [DATA_WIDTH-1:0]                register_file_write_data,
    output logic                                 register_file_read_en,
    input  logic                                 register_file_read_data_valid,
    input  logic [DATA_WIDTH-1:0]                register_file_read_data
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT_RD} state_t;
    state_t state, state_next;
    logic [GW-1:0] last_grant, winner, grant;
    logic [ADDR_W-1:0] win_address;
    logic [DATA_WIDTH-1:0] win_data;
    logic win_write, win_in_range, cur_write, cur_in_range, rd_ok, rd_timeout, rsp_fire;
    logic [TW-1:0] timer;

    // Scan farthest-to-nearest from last_grant so the nearest valid requester overwrites last.
    always_comb begin
        winner = last_grant;
        for (int k = NUM_REQUESTERS; k >= 1; k--)
            if (req_valid[(int'(last_grant) + k) % NUM_REQUESTERS])
                winner = GW'((int'(last_grant) + k) % NUM_REQUESTERS);
        win_address  = req_address[int'(winner)*ADDR_W +: ADDR_W];
        win_data     = req_write_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
        win_write    = req_write[winner];
        win_in_range = int'(win_address) < REGISTER_FILE_DEPTH;
        rd_ok        = state == WAIT_RD && register_file_read_data_valid;
        rd_timeout   = state == WAIT_RD && int'(timer) == READ_TIMEOUT - 1;
        rsp_fire     = rd_ok || rd_timeout || (state == ACCESS && !cur_write && !cur_in_range);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = |req_valid ? ACCESS : IDLE;
            ACCESS:  state_next = (cur_write || !cur_in_range) ? IDLE : WAIT_RD;
            WAIT_RD: state_next = (rd_ok || rd_timeout) ? IDLE : WAIT_RD;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant               <= GW'(NUM_REQUESTERS - 1);
            grant                    <= '0;
            cur_write                <= 1'b0;
            cur_in_range             <= 1'b0;
            timer                    <= '0;
            req_ready                <= '0;
            rsp_valid                <= '0;
            rsp_error                <= 1'b0;
            rsp_data                 <= '0;
            register_file_address    <= '0;
            register_file_write_en   <= 1'b0;
            register_file_write_data <= '0;
            register_file_read_en    <= 1'b0;
        end else begin
            req_ready              <= '0;
            rsp_valid              <= '0;
            register_file_write_en <= 1'b0;
            register_file_read_en  <= 1'b0;
            timer                  <= state == WAIT_RD ? timer + 1'b1 : '0;
            if (state == IDLE && |req_valid) begin
                grant                    <= winner;
                last_grant               <= winner;
                cur_write                <= win_write;
                cur_in_range             <= win_in_range;
                register_file_address    <= win_address;
                register_file_write_data <= win_data;
                req_ready                <= NUM_REQUESTERS'(1) << winner;
                register_file_write_en   <= win_write && win_in_range;
                register_file_read_en    <= !win_write && win_in_range;
            end
            if (rsp_fire) begin
                rsp_valid <= NUM_REQUESTERS'(1) << grant;
                rsp_error <= !rd_ok;
                rsp_data  <= rd_ok ? register_file_read_data : '0;
            end
        end
    end
endmodule

// File: tb/tb_register_file_arbiter.sv
// tb_register_file_arbiter: random multi-master traffic against a transaction-level model with
// round-robin grant prediction, a behavioural register file and a response scoreboard.
module tb_register_file_arbiter;
    localparam int N = 2, DW = 8, DEPTH = 12, AW = 4, TO = 4;

    logic clk = 1'b0, reset = 1'b1;
    logic [N-1:0] req_valid = '0, req_write = '0;
    logic [N*AW-1:0] req_address = '0;
    logic [N*DW-1:0] req_write_data = '0;
    logic [N-1:0] req_ready, rsp_valid;
    logic rsp_error;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] register_file_address;
    logic register_file_write_en, register_file_read_en;
    logic [DW-1:0] register_file_write_data;
    logic register_file_read_data_valid = 1'b0;
    logic [DW-1:0] register_file_read_data = '0;

    register_file_arbiter #(
        .DATA_WIDTH(DW), .REGISTER_FILE_DEPTH(DEPTH), .NUM_REQUESTERS(N), .READ_TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_address(req_address),
        .req_write_data(req_write_data), .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_error(rsp_error), .rsp_data(rsp_data),
        .register_file_address(register_file_address),
        .register_file_write_en(register_file_write_en),
        .register_file_write_data(register_file_write_data),
        .register_file_read_en(register_file_read_en),
        .register_file_read_data_valid(register_file_read_data_valid),
        .register_file_read_data(register_file_read_data)
    );

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          w;
        bit [AW-1:0] a;
        bit [DW-1:0] d;
        bit          drop;
        int          lat;
    } txn_t;

    txn_t exp_q [N][$];
    bit [DW-1:0] rf [16];
    bit [DW-1:0] mem [16];
    bit acked [N];
    bit active [N];
    int tests = 0, fails = 0;
    int free_at = 0, ready_at = -1, rsp_due = -1, win = 0, rsp_who = 0, last = N - 1;
    bit rsp_err;
    bit [DW-1:0] rsp_exp;
    bit pend = 1'b0;
    int pend_cyc = 0;
    bit [DW-1:0] pend_data;
    bit gen_en = 1'b0;
    int rate = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Scoreboard monitor: predicts grants and response timing, plays the register file's read side.
    initial begin
        txn_t t;
        bit in_r;
        int w;
        forever begin
            @(negedge clk);
            if (reset) begin
                ready_at = -1;
                rsp_due  = -1;
                last     = N - 1;
                free_at  = cyc + 1;
                pend     = 1'b0;
            end else begin
                if (ready_at == cyc) begin
                    chk("grant", 32'(req_ready), 32'(1 << win));
                    ready_at = -1;
                    if (exp_q[win].size() == 0) chk("grant_expected", 32'(0), 32'(1));
                    else begin
                        t = exp_q[win].pop_front();
                        acked[win] = 1'b1;
                        last = win;
                        in_r = int'(t.a) < DEPTH;
                        chk("write_en", 32'(register_file_write_en), 32'(t.w && in_r));
                        chk("read_en", 32'(register_file_read_en), 32'(!t.w && in_r));
                        if (in_r) chk("address", 32'(register_file_address), 32'(t.a));
                        if (in_r && t.w) chk("write_data", 32'(register_file_write_data), 32'(t.d));
                        if (t.w) begin
                            if (in_r) mem[t.a] = t.d;
                            free_at = cyc + 1;
                        end else begin
                            rsp_who = win;
                            if (!in_r || t.drop) begin
                                rsp_due = cyc + (in_r ? TO + 1 : 1);
                                rsp_err = 1'b1;
                                rsp_exp = '0;
                            end else begin
                                rsp_due = cyc + t.lat + 1;
                                rsp_err = 1'b0;
                                rsp_exp = mem[t.a];
                            end
                            free_at = rsp_due;
                            if (register_file_read_en && in_r && !t.drop) begin
                                pend = 1'b1;
                                pend_cyc = cyc + t.lat;
                                pend_data = rf[register_file_address];
                            end
                        end
                    end
                end else
                    chk("quiet", 32'({req_ready, register_file_write_en, register_file_read_en}), 32'(0));
                if (rsp_due == cyc) begin
                    chk("rsp_valid", 32'(rsp_valid), 32'(1 << rsp_who));
                    chk("rsp_error", 32'(rsp_error), 32'(rsp_err));
                    chk("rsp_data", 32'(rsp_data), 32'(rsp_exp));
                    rsp_due = -1;
                end else
                    chk("rsp_quiet", 32'(rsp_valid), 32'(0));
                if (register_file_write_en) rf[register_file_address] = register_file_write_data;
                if (ready_at < 0 && cyc >= free_at && |req_valid) begin
                    w = -1;
                    for (int k = 1; k <= N; k++)
                        if (w < 0 && req_valid[(last + k) % N]) w = (last + k) % N;
                    win = w;
                    ready_at = cyc + 1;
                end
            end
        end
    end

    // Register file read side: returns data after the chosen latency, plus stray valids when no read is open.
    initial forever begin
        @(posedge clk);
        #1;
        if (pend && cyc == pend_cyc) begin
            register_file_read_data_valid = 1'b1;
            register_file_read_data = pend_data;
            pend = 1'b0;
        end else begin
            register_file_read_data_valid = !pend && rsp_due < 0 && $urandom_range(0, 7) == 0;
            register_file_read_data = DW'($urandom);
        end
    end

    function automatic txn_t rnd_txn();
        txn_t t;
        t.w    = 1'($urandom_range(0, 1));
        t.a    = AW'($urandom_range(0, 15));
        t.d    = DW'($urandom);
        t.drop = $urandom_range(0, 6) == 0;
        t.lat  = int'($urandom_range(1, 3));
        return t;
    endfunction

    task automatic issue(input int i, input txn_t t);
        active[i] = 1'b1;
        exp_q[i].push_back(t);
        req_valid[i] = 1'b1;
        req_write[i] = t.w;
        req_address[i*AW +: AW] = t.a;
        req_write_data[i*DW +: DW] = t.d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acked[i]) begin
                acked[i] = 1'b0;
                active[i] = 1'b0;
                req_valid[i] = 1'b0;
                req_write[i] = 1'($urandom);
                req_address[i*AW +: AW] = AW'($urandom);
                req_write_data[i*DW +: DW] = DW'($urandom);
            end
            if (!active[i] && gen_en && $urandom_range(0, 99) < rate) issue(i, rnd_txn());
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((active[0] || active[1] || ready_at >= 0 || rsp_due >= 0) && n < 200) begin
            step();
            n++;
        end
        chk("drain", 32'(n < 200), 32'(1));
    endtask

    task automatic run_one(input int i, input bit w, input int a, input int d, input bit drop, input int lat);
        txn_t t;
        t.w = w;
        t.a = AW'(a);
        t.d = DW'(d);
        t.drop = drop;
        t.lat = lat;
        issue(i, t);
        wait_idle();
    endtask

    initial begin
        txn_t t;
        int n;
        for (int k = 0; k < 16; k++) begin
            rf[k] = DW'($urandom);
            mem[k] = rf[k];
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_state", 32'({req_ready, rsp_valid, rsp_error, rsp_data, register_file_address,
            register_file_write_en, register_file_write_data, register_file_read_en}), 32'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_one(0, 1'b1, 2, 'hA5, 1'b0, 1);
        run_one(0, 1'b1, 3, 'h3C, 1'b0, 1);
        run_one(1, 1'b0, 3, 0, 1'b0, 1);
        run_one(1, 1'b0, 5, 0, 1'b1, 1);
        run_one(0, 1'b0, 13, 0, 1'b0, 1);
        run_one(1, 1'b1, 13, 'h77, 1'b0, 1);
        run_one(0, 1'b0, 2, 0, 1'b0, 3);
        gen_en = 1'b1;
        rate = 100;
        repeat (200) step();
        rate = 40;
        repeat (3000) step();
        gen_en = 1'b0;
        wait_idle();
        // Reset while a read from req 0 is stuck in WAIT_RD; req 0 must still win next.
        t.w = 1'b0; t.a = 4'd4; t.d = '0; t.drop = 1'b1; t.lat = 1;
        issue(0, t);
        n = 0;
        while (!acked[0] && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reset_setup", 32'(acked[0]), 32'(1));
        reset = 1'b1;
        req_valid = '0;
        for (int i = 0; i < N; i++) begin
            acked[i] = 1'b0;
            active[i] = 1'b0;
            exp_q[i].delete();
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < N; i++) begin
            t = rnd_txn();
            t.w = 1'b1;
            t.a = AW'(i + 6);
            issue(i, t);
        end
        @(negedge clk);
        chk("post_reset", 32'({req_ready, rsp_valid, rsp_error, rsp_data, register_file_address,
            register_file_write_en, register_file_write_data, register_file_read_en}), 32'(0));
        wait_idle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
